// File: rtl/pll_sup_pkg.sv
// Shared types and default timing constants for the PLL supervisor.
// Main and phase-step state encodings live here.
package pll_sup_pkg;

    localparam int DEF_RST_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT  = 65535;
    localparam int DEF_STABLE_CYCLES = 1023;
    localparam int DEF_STEP_PULSE    = 4;
    localparam int DEF_SETTLE        = 4;

    typedef enum logic [1:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        RUN
    } main_state_t;

    typedef enum logic [2:0] {
        P_IDLE,
        P_SETUP,
        P_STEP,
        P_SETTLE,
        P_DONE
    } phase_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for the asynchronous PLL lock indication.
// Both flops clear on the synchronous reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_supervisor.sv
// PLL bring-up supervisor: reset/lock/stability sequencing with retry
// counting, plus a dynamic phase-step sequencer active only in RUN.
module pll_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int STEP_PULSE    = DEF_STEP_PULSE,
    parameter int SETTLE        = DEF_SETTLE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_reset,
    output logic       ready,
    output logic [7:0] retry_count,
    input  logic       phase_req,
    input  logic [1:0] phase_sel,
    input  logic       phase_dir,
    output logic       phase_ack,
    output logic [1:0] pll_phasesel,
    output logic       pll_phasedir,
    output logic       pll_phasestep,
    output logic       pll_phaseloadreg
);

    localparam logic [31:0] RST_LAST = 32'(RST_CYCLES - 1);
    localparam logic [31:0] TO_LAST  = 32'(LOCK_TIMEOUT - 1);
    localparam logic [31:0] ST_LAST  = 32'(STABLE_CYCLES - 1);
    localparam logic [15:0] SP_LAST  = 16'(STEP_PULSE - 1);
    localparam logic [15:0] SE_LAST  = 16'(SETTLE - 1);

    logic         lock_s;
    main_state_t  state, state_n;
    logic [31:0]  cnt, cnt_n;
    logic         retry_inc;
    phase_state_t pstate, pstate_n;
    logic [15:0]  pcnt, pcnt_n;
    logic         latch;
    logic         armed;
    logic         run_n;
    logic         start;

    assign pll_phaseloadreg = 1'b1;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lock_s)
    );

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        retry_inc = 1'b0;
        unique case (state)
            RESET_PLL: begin
                if (cnt == RST_LAST) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 32'd1;
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_n = STABLE;
                    cnt_n   = '0;
                end else if (cnt == TO_LAST) begin
                    state_n   = RESET_PLL;
                    cnt_n     = '0;
                    retry_inc = 1'b1;
                end else begin
                    cnt_n = cnt + 32'd1;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end else if (cnt == ST_LAST) begin
                    state_n = RUN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 32'd1;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_n   = RESET_PLL;
                    cnt_n     = '0;
                    retry_inc = 1'b1;
                end
            end
            default: begin
                state_n = RESET_PLL;
                cnt_n   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they track state exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RESET_PLL;
            cnt         <= '0;
            retry_count <= '0;
            pll_rst     <= 1'b1;
            sys_reset   <= 1'b1;
            ready       <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            pll_rst   <= (state_n == RESET_PLL);
            sys_reset <= (state_n != RUN);
            ready     <= (state_n == RUN);
            if (retry_inc && retry_count != 8'hFF)
                retry_count <= retry_count + 8'd1;
        end
    end

    assign run_n = (state_n == RUN);
    assign start = phase_req && armed && (state == RUN);

    always_comb begin
        pstate_n = pstate;
        pcnt_n   = pcnt;
        latch    = 1'b0;
        if (!run_n) begin
            pstate_n = P_IDLE;
            pcnt_n   = '0;
        end else begin
            unique case (pstate)
                P_IDLE: begin
                    if (start) begin
                        pstate_n = P_SETUP;
                        latch    = 1'b1;
                    end
                end
                P_SETUP: begin
                    pstate_n = P_STEP;
                    pcnt_n   = '0;
                end
                P_STEP: begin
                    if (pcnt == SP_LAST) begin
                        pstate_n = P_SETTLE;
                        pcnt_n   = '0;
                    end else begin
                        pcnt_n = pcnt + 16'd1;
                    end
                end
                P_SETTLE: begin
                    if (pcnt == SE_LAST) begin
                        pstate_n = P_DONE;
                        pcnt_n   = '0;
                    end else begin
                        pcnt_n = pcnt + 16'd1;
                    end
                end
                P_DONE:  pstate_n = P_IDLE;
                default: pstate_n = P_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pstate        <= P_IDLE;
            pcnt          <= '0;
            armed         <= 1'b1;
            phase_ack     <= 1'b0;
            pll_phasestep <= 1'b1;
            pll_phasesel  <= '0;
            pll_phasedir  <= 1'b0;
        end else begin
            pstate        <= pstate_n;
            pcnt          <= pcnt_n;
            pll_phasestep <= (pstate_n != P_STEP);
            phase_ack     <= (pstate_n == P_DONE);
            if (latch) begin
                pll_phasesel <= phase_sel;
                pll_phasedir <= phase_dir;
            end
            // A request must drop before another step can be armed.
            if (pstate == P_DONE)
                armed <= 1'b0;
            else if (!phase_req)
                armed <= 1'b1;
        end
    end

endmodule
